count_sequencer: RTL and testbench

- Controller that sequences a two-stage counter datapath.
- Stage 1 is a modulo prescale counter (count, 0..prescale). Stage 2 is a down-counting event counter (count2, reload..0).
- Accepts run-time configuration through a valid/ready handshake, starts and aborts runs, and stretches each prescale wrap into a fixed-length led pulse.
- Signals busy/done to the surrounding control logic; sits between the top-level control and the status LED.

---
 rtl/count_sequencer.sv | 138 +++++++++++++
 tb/tb_count_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : count_sequencer
// Brief   : Sequencer for a prescale counter feeding a down-counting event
//           counter, with cfg handshake, start/abort and a stretched led pulse.
// Rev     : 1.0
// ============================================================================
module count_sequencer #(
    parameter int W          = 4,
    parameter int PRE_DEF    = 12,
    parameter int RELOAD_DEF = 15,
    parameter int PULSE_LEN  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_prescale,
    input  logic [W-1:0] cfg_reload,
    output logic         cfg_ready,
    input  logic         start,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] count,
    output logic [W-1:0] count2,
    output logic         led
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [W-1:0] PRE_INIT    = W'(PRE_DEF);
    localparam logic [W-1:0] RELOAD_INIT = W'(RELOAD_DEF);
    localparam logic [W-1:0] PULSE_INIT  = W'(PULSE_LEN - 1);

    logic [1:0]   state, state_nxt;
    logic [W-1:0] prescale_q, prescale_nxt;
    logic [W-1:0] reload_q, reload_nxt;
    logic [W-1:0] count_nxt, count2_nxt;
    logic [W-1:0] timer, timer_nxt;
    logic         led_nxt;
    logic         done_nxt;
    logic         fire;
    logic         kill;

    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN) || (state == S_DONE);

    always_comb begin
        state_nxt    = state;
        prescale_nxt = prescale_q;
        reload_nxt   = reload_q;
        count_nxt    = count;
        count2_nxt   = count2;
        done_nxt     = 1'b0;
        fire         = 1'b0;
        kill         = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_valid) begin
                    prescale_nxt = cfg_prescale;
                    reload_nxt   = cfg_reload;
                end
                // A same-edge cfg offer wins over the stored reload value
                if (start) begin
                    state_nxt  = S_RUN;
                    count_nxt  = '0;
                    count2_nxt = cfg_valid ? cfg_reload : reload_q;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                    kill      = 1'b1;
                end else if (count == prescale_q) begin
                    count_nxt = '0;
                    fire      = 1'b1;
                    if (count2 == '0) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        count2_nxt = count2 - 1'b1;
                    end
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                kill      = abort;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A wrap while the pulse is still active simply restarts the timer
    always_comb begin
        led_nxt   = led;
        timer_nxt = timer;
        if (kill) begin
            led_nxt   = 1'b0;
            timer_nxt = '0;
        end else if (fire) begin
            led_nxt   = 1'b1;
            timer_nxt = PULSE_INIT;
        end else if (timer != '0) begin
            timer_nxt = timer - 1'b1;
        end else begin
            led_nxt = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            prescale_q <= PRE_INIT;
            reload_q   <= RELOAD_INIT;
            count      <= '0;
            count2     <= RELOAD_INIT;
            timer      <= '0;
            led        <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            prescale_q <= prescale_nxt;
            reload_q   <= reload_nxt;
            count      <= count_nxt;
            count2     <= count2_nxt;
            timer      <= timer_nxt;
            led        <= led_nxt;
            done       <= done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_count_sequencer
// Brief   : Randomized scoreboard bench for count_sequencer; expected wrap
//           schedule and led envelope are computed from run arithmetic.
// Rev     : 1.0
// ============================================================================
module tb_count_sequencer;

    localparam int W  = 4;
    localparam int PL = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_prescale = '0;
    logic [W-1:0] cfg_reload = '0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         cfg_ready, busy, done, led;
    logic [W-1:0] count, count2;

    count_sequencer #(
        .W(W), .PRE_DEF(12), .RELOAD_DEF(15), .PULSE_LEN(PL)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_prescale(cfg_prescale), .cfg_reload(cfg_reload),
        .cfg_ready(cfg_ready), .start(start), .abort(abort),
        .busy(busy), .done(done), .count(count), .count2(count2), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_no;
        int c2;
        int last;
    } exp_t;

    exp_t sb[$];
    bit   led_exp [0:32767];
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   cur_p = 12;
    int   cur_r = 15;
    int   k_edge, end_edge, abort_edge, exp_c2_end;

    // Active edge is the falling edge; count them so schedules are absolute
    initial forever begin
        @(negedge clk);
        edge_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic slot();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a wrap is visible as count==0 while busy on consecutive samples
    initial begin
        bit   prev_busy;
        bit   ev;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(posedge clk);
            if (mon_en) begin
                ev = busy && (count == '0) && prev_busy;
                if (ev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_wrap", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("wrap_edge", edge_cnt, e.edge_no);
                        check("wrap_count2", int'(count2), e.c2);
                        check("wrap_done", int'(done), e.last);
                    end
                end else if (done) begin
                    check("spurious_done", int'(done), 0);
                end
                check("led", int'(led), int'(led_exp[edge_cnt]));
            end
            prev_busy = busy;
        end
    end

    // mode 0: reuse stored cfg, 1: cfg transfer first, 2: cfg on the start edge
    task automatic do_start(input int mode, input int p, input int r, input int abort_off);
        int total;
        int w;
        if (mode == 1) begin
            check("cfg_ready_idle", int'(cfg_ready), 1);
            cfg_valid = 1'b1; cfg_prescale = W'(p); cfg_reload = W'(r);
            slot();
            cfg_valid = 1'b0;
            cur_p = p; cur_r = r;
        end else if (mode == 2) begin
            cfg_valid = 1'b1; cfg_prescale = W'(p); cfg_reload = W'(r);
            cur_p = p; cur_r = r;
        end
        start  = 1'b1;
        k_edge = edge_cnt + 1;
        slot();
        start = 1'b0; cfg_valid = 1'b0;
        total      = (cur_r + 1) * (cur_p + 1);
        abort_edge = (abort_off == 0) ? 0 : k_edge + abort_off;
        exp_c2_end = cur_r;
        for (int n = 1; n <= cur_r + 1; n++) begin
            w = k_edge + n * (cur_p + 1);
            if (abort_edge == 0 || w < abort_edge) begin
                sb.push_back('{w, (n <= cur_r) ? cur_r - n : 0, (n == cur_r + 1) ? 1 : 0});
                for (int j = 0; j < PL; j++) led_exp[w + j] = 1'b1;
                exp_c2_end = (n <= cur_r) ? cur_r - n : 0;
            end
        end
        if (abort_edge != 0)
            for (int j = abort_edge; j < abort_edge + PL + 1; j++) led_exp[j] = 1'b0;
        end_edge = (abort_edge != 0) ? abort_edge : k_edge + total + 1;
    endtask

    task automatic finish_run(input bit junk);
        while (edge_cnt < end_edge) begin
            if (junk) begin
                cfg_valid    = 1'($urandom_range(0, 1));
                cfg_prescale = W'($urandom);
                cfg_reload   = W'($urandom);
                start        = 1'($urandom_range(0, 1));
            end
            abort = (abort_edge != 0) && (edge_cnt + 1 == abort_edge);
            slot();
        end
        cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        check("end_busy", int'(busy), 0);
        check("end_cfg_ready", int'(cfg_ready), 1);
        check("end_done", int'(done), 0);
        check("end_count", int'(count), 0);
        check("end_count2", int'(count2), exp_c2_end);
    endtask

    initial begin
        int p, r, mode, ab, pp, rr;
        repeat (3) slot();
        check("rst_count", int'(count), 0);
        check("rst_count2", int'(count2), 15);
        check("rst_led", int'(led), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        rst = 1'b1;
        mon_en = 1'b1;
        slot();

        do_start(0, 0, 0, 0);   finish_run(1'b0);   // defaults 12/15
        do_start(1, 3, 2, 0);   finish_run(1'b1);
        do_start(2, 0, 1, 0);   finish_run(1'b0);   // continuous led
        do_start(1, 12, 15, 19); finish_run(1'b0);  // abort at count=5, count2=14

        // Reset mid-run with a non-default cfg loaded
        do_start(1, 5, 3, 0);
        repeat (10) slot();
        rst = 1'b0;
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_count2", int'(count2), 15);
        check("mid_rst_led", int'(led), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cfg_ready", int'(cfg_ready), 1);
        sb.delete();
        for (int j = edge_cnt + 1; j < edge_cnt + 400; j++) led_exp[j] = 1'b0;
        cur_p = 12; cur_r = 15;
        slot();
        rst = 1'b1;
        slot();
        do_start(0, 0, 0, 0);   finish_run(1'b1);

        for (int i = 0; i < 10; i++) begin
            p    = int'($urandom_range(0, 15));
            r    = int'($urandom_range(0, 15));
            mode = int'($urandom_range(0, 2));
            pp   = (mode == 0) ? cur_p : p;
            rr   = (mode == 0) ? cur_r : r;
            ab   = 0;
            if ($urandom_range(0, 2) == 0)
                ab = int'($urandom_range(1, (rr + 1) * (pp + 1) + 1));
            do_start(mode, p, r, ab);
            finish_run(1'b1);
        end

        repeat (PL + 2) slot();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
